// File: rtl/slicel_config_loader.sv
// Configuration loader for one SLICEL: collects a word-serial frame plus an XOR
// checksum into a shadow register and commits it to the slice config outputs.
module slicel_config_loader #(
   parameter int S_XX_BASE = 4,
   parameter int NUM_LUTS  = 4,
   parameter int CFG_SIZE  = 2*(2**S_XX_BASE)+1,
   parameter int MUX_LVLS  = $clog2(NUM_LUTS),
   parameter int WORD_W    = 8
) (
   input  logic                         cclk,
   input  logic                         rst_n,
   input  logic                         cfg_start,
   input  logic [WORD_W-1:0]            cfg_data,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_in,
   output logic [MUX_LVLS-1:0]          inter_lut_mux_config,
   output logic                         config_use_cc,
   output logic [2*NUM_LUTS-1:0]        regs_config_in,
   output logic                         cen,
   output logic                         cfg_done,
   output logic                         cfg_err
);
   localparam int LUT_BITS   = CFG_SIZE*NUM_LUTS;
   localparam int FRAME_BITS = LUT_BITS + MUX_LVLS + 1 + 2*NUM_LUTS;
   localparam int NUM_WORDS  = (FRAME_BITS + WORD_W - 1) / WORD_W;
   localparam int SH_W       = NUM_WORDS*WORD_W;
   localparam int CNT_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT, S_DONE, S_ERR} state_t;

   state_t                r_state, w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [WORD_W-1:0]     r_acc;
   logic [FRAME_BITS-1:0] r_shadow;
   logic [FRAME_BITS-1:0] r_frame;
   logic                  w_accept;

   assign cfg_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
   // cfg_start wins over any word presented in the same cycle
   assign w_accept  = cfg_valid && cfg_ready && !cfg_start;
   assign cen       = (r_state == S_COMMIT);
   assign cfg_done  = (r_state == S_DONE);
   assign cfg_err   = (r_state == S_ERR);

   always_comb begin
      w_next = r_state;
      if (cfg_start) begin
         w_next = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD:   if (w_accept && r_cnt == CNT_W'(NUM_WORDS-1)) w_next = S_CHECK;
            S_CHECK:  if (w_accept) w_next = (cfg_data == r_acc) ? S_COMMIT : S_ERR;
            S_COMMIT: w_next = S_DONE;
            default:  w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Shadow is cleared on start and each slot is written once, so OR-in suffices;
   // the truncating cast drops padding bits of the last word.
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_shadow <= '0;
      end else if (cfg_start) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_shadow <= '0;
      end else if (r_state == S_LOAD && w_accept) begin
         r_cnt    <= r_cnt + 1'b1;
         r_acc    <= r_acc ^ cfg_data;
         r_shadow <= r_shadow | FRAME_BITS'(SH_W'(cfg_data) << (WORD_W*r_cnt));
      end
   end

   // Loading on entry to COMMIT makes the new frame visible while cen is high.
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n)                                     r_frame <= '0;
      else if (r_state == S_CHECK && w_next == S_COMMIT) r_frame <= r_shadow;
   end

   assign luts_config_in       = r_frame[LUT_BITS-1:0];
   assign inter_lut_mux_config = r_frame[LUT_BITS +: MUX_LVLS];
   assign config_use_cc        = r_frame[LUT_BITS + MUX_LVLS];
   assign regs_config_in       = r_frame[LUT_BITS + MUX_LVLS + 1 +: 2*NUM_LUTS];
endmodule

// File: tb/tb_slicel_config_loader.sv
// Directed bench for slicel_config_loader at default parameters (143-bit frame, 18 words).
module tb_slicel_config_loader;
   logic         cclk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_start = 1'b0;
   logic [7:0]   cfg_data = 8'h00;
   logic         cfg_valid = 1'b0;
   logic         cfg_ready;
   logic [131:0] luts_config_in;
   logic [1:0]   inter_lut_mux_config;
   logic         config_use_cc;
   logic [7:0]   regs_config_in;
   logic         cen, cfg_done, cfg_err;

   int n_chk = 0;
   int n_fail = 0;
   int cen_cnt = 0;

   // Frame A: bytes 0x01..0x12. XOR of 0x01..0x12 is 0x13, so 0x13 is the good checksum.
   localparam logic [131:0] A_LUT  = 132'h1_10_0f_0e_0d_0c_0b_0a_09_08_07_06_05_04_03_02_01;
   localparam logic [1:0]   A_MUX  = 2'b01;
   localparam logic         A_CC   = 1'b0;
   localparam logic [7:0]   A_REGS = 8'h24;
   localparam logic [142:0] FRAME_A = {A_REGS, A_CC, A_MUX, A_LUT};
   // Frame B: all 0xFF, even word count so checksum 0x00.
   localparam logic [142:0] FRAME_B = {143{1'b1}};

   slicel_config_loader dut (
      .cclk(cclk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_data(cfg_data),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .luts_config_in(luts_config_in),
      .inter_lut_mux_config(inter_lut_mux_config), .config_use_cc(config_use_cc),
      .regs_config_in(regs_config_in), .cen(cen), .cfg_done(cfg_done), .cfg_err(cfg_err)
   );

   always #5 cclk = ~cclk;
   always @(posedge cclk) if (cen === 1'b1) cen_cnt <= cen_cnt + 1;

   wire [142:0] w_outs = {regs_config_in, config_use_cc, inter_lut_mux_config, luts_config_in};

   task automatic tick();
      @(posedge cclk); #1;
   endtask

   function automatic logic [7:0] fbyte(input bit is_a, input int k);
      return is_a ? 8'(k + 1) : 8'hFF;
   endfunction

   task automatic start();
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hEE;
      tick();
      cfg_start = 1'b0; cfg_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit gaps);
      int w = 0;
      if (gaps) while ($urandom_range(1, 0) == 0) begin cfg_valid = 1'b0; tick(); end
      cfg_data = d; cfg_valid = 1'b1;
      while (cfg_ready !== 1'b1 && w < 50) begin tick(); w++; end
      n_chk++;
      if (cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL send_ready: cfg_ready=%b required 1", cfg_ready);
      end
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic load(input bit is_a, input logic [7:0] csum, input bit gaps);
      start();
      for (int k = 0; k < 18; k++) send(fbyte(is_a, k), gaps);
      send(csum, gaps);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; #3;
      n_chk++;
      if (w_outs !== 143'd0 || cfg_ready !== 1'b0 || cen !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: outs=%h rdy=%b cen=%b done=%b err=%b required all 0", w_outs, cfg_ready, cen, cfg_done, cfg_err);
      end
      tick(); rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cfg_valid = 1'b1; tick();
         n_chk++;
         if (cfg_ready !== 1'b0 || cen !== 1'b0 || w_outs !== 143'd0) begin
            n_fail++; $display("FAIL idle_quiet: rdy=%b cen=%b outs=%h required 0", cfg_ready, cen, w_outs);
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_frame_b();
      int c0 = cen_cnt;
      load(1'b0, 8'h00, 1'b0);
      n_chk++;
      if (cen !== 1'b1 || w_outs !== FRAME_B) begin
         n_fail++; $display("FAIL b_commit: cen=%b outs=%h required cen 1 outs %h", cen, w_outs, FRAME_B);
      end
      tick();
      n_chk++;
      if (cen !== 1'b0 || cfg_done !== 1'b1 || cfg_err !== 1'b0 || cen_cnt - c0 != 1) begin
         n_fail++; $display("FAIL b_done: cen=%b done=%b err=%b pulses=%0d required 0 1 0 1", cen, cfg_done, cfg_err, cen_cnt - c0);
      end
   endtask

   task automatic test_bad_checksum();
      int c0 = cen_cnt;
      load(1'b1, 8'h12, 1'b0);
      n_chk++;
      if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || cen !== 1'b0) begin
         n_fail++; $display("FAIL bad_err: err=%b done=%b cen=%b required 1 0 0", cfg_err, cfg_done, cen);
      end
      cfg_valid = 1'b1; cfg_data = 8'h13;
      for (int i = 0; i < 4; i++) tick();
      cfg_valid = 1'b0;
      n_chk++;
      if (cfg_err !== 1'b1 || cfg_ready !== 1'b0 || w_outs !== FRAME_B || cen_cnt != c0) begin
         n_fail++; $display("FAIL bad_hold: err=%b rdy=%b outs=%h pulses=%0d required 1 0 %h 0", cfg_err, cfg_ready, w_outs, cen_cnt - c0, FRAME_B);
      end
   endtask

   task automatic test_frame_a();
      int c0 = cen_cnt;
      load(1'b1, 8'h13, 1'b0);
      n_chk++;
      if (cen !== 1'b1 || luts_config_in[7:0] !== 8'h01 || luts_config_in !== A_LUT) begin
         n_fail++; $display("FAIL a_luts: cen=%b luts=%h required 1 %h", cen, luts_config_in, A_LUT);
      end
      n_chk++;
      if (inter_lut_mux_config !== A_MUX || config_use_cc !== A_CC || regs_config_in !== A_REGS) begin
         n_fail++; $display("FAIL a_fields: mux=%b cc=%b regs=%h required %b %b %h", inter_lut_mux_config, config_use_cc, regs_config_in, A_MUX, A_CC, A_REGS);
      end
      cfg_valid = 1'b1; cfg_data = 8'h55;
      for (int i = 0; i < 4; i++) tick();
      cfg_valid = 1'b0;
      n_chk++;
      if (cfg_done !== 1'b1 || cfg_ready !== 1'b0 || w_outs !== FRAME_A || cen_cnt - c0 != 1) begin
         n_fail++; $display("FAIL a_done: done=%b rdy=%b pulses=%0d outs=%h required 1 0 1 %h", cfg_done, cfg_ready, cen_cnt - c0, w_outs, FRAME_A);
      end
   endtask

   task automatic test_gaps();
      int c0 = cen_cnt;
      load(1'b0, 8'h00, 1'b1);
      tick(); tick();
      n_chk++;
      if (w_outs !== FRAME_B || cfg_done !== 1'b1 || cen_cnt - c0 != 1) begin
         n_fail++; $display("FAIL gaps: outs=%h done=%b pulses=%0d required %h 1 1", w_outs, cfg_done, cen_cnt - c0, FRAME_B);
      end
   endtask

   task automatic test_restart();
      int c0 = cen_cnt;
      start();
      for (int k = 0; k < 7; k++) send(fbyte(1'b0, k), 1'b0);
      n_chk++;
      if (w_outs !== FRAME_B || cen_cnt != c0) begin
         n_fail++; $display("FAIL restart_partial: outs=%h pulses=%0d required %h 0", w_outs, cen_cnt - c0, FRAME_B);
      end
      load(1'b1, 8'h13, 1'b0);
      tick();
      n_chk++;
      if (w_outs !== FRAME_A || cfg_done !== 1'b1 || cen_cnt - c0 != 1) begin
         n_fail++; $display("FAIL restart: outs=%h done=%b pulses=%0d required %h 1 1", w_outs, cfg_done, cen_cnt - c0, FRAME_A);
      end
   endtask

   task automatic test_reset_midload();
      int c0;
      start();
      for (int k = 0; k < 10; k++) send(fbyte(1'b0, k), 1'b0);
      #2 rst_n = 1'b0; #1;
      n_chk++;
      if (w_outs !== 143'd0 || cfg_ready !== 1'b0 || cen !== 1'b0 || cfg_done !== 1'b0) begin
         n_fail++; $display("FAIL midload_reset: outs=%h rdy=%b cen=%b done=%b required 0", w_outs, cfg_ready, cen, cfg_done);
      end
      tick(); rst_n = 1'b1;
      c0 = cen_cnt;
      cfg_valid = 1'b1; cfg_data = 8'hFF;
      for (int i = 0; i < 20; i++) tick();
      cfg_valid = 1'b0;
      n_chk++;
      if (cen_cnt != c0 || cfg_ready !== 1'b0 || w_outs !== 143'd0) begin
         n_fail++; $display("FAIL post_reset_idle: pulses=%0d rdy=%b outs=%h required 0 0 0", cen_cnt - c0, cfg_ready, w_outs);
      end
      load(1'b0, 8'h00, 1'b0);
      tick();
      n_chk++;
      if (w_outs !== FRAME_B || cfg_done !== 1'b1 || cen_cnt - c0 != 1) begin
         n_fail++; $display("FAIL reload_after_reset: outs=%h done=%b pulses=%0d required %h 1 1", w_outs, cfg_done, cen_cnt - c0, FRAME_B);
      end
   endtask

   task automatic test_start_in_commit();
      int c0 = cen_cnt;
      load(1'b1, 8'h13, 1'b0);
      cfg_start = 1'b1; #1;
      n_chk++;
      if (cen !== 1'b1 || w_outs !== FRAME_A) begin
         n_fail++; $display("FAIL commit_start_cen: cen=%b outs=%h required 1 %h", cen, w_outs, FRAME_A);
      end
      tick(); cfg_start = 1'b0;
      n_chk++;
      if (cfg_ready !== 1'b1 || cfg_done !== 1'b0 || cen !== 1'b0 || w_outs !== FRAME_A || cen_cnt - c0 != 1) begin
         n_fail++; $display("FAIL commit_start_load: rdy=%b done=%b cen=%b pulses=%0d outs=%h required 1 0 0 1 %h", cfg_ready, cfg_done, cen, cen_cnt - c0, w_outs, FRAME_A);
      end
   endtask

   initial begin
      test_reset();
      test_frame_b();
      test_bad_checksum();
      test_frame_a();
      test_gaps();
      test_restart();
      test_reset_midload();
      test_start_in_commit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
